// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register and ALU operand-select stage.
//
// Captures a decoded instruction from decode through a valid/ready handshake.
// It holds that instruction until EX accepts it. While it holds, it builds the
// ALU operands from the stored register values, the immediate or the shift
// amount.
//
// Optional feature (macro ID_EX_FWD_EN):
//   defined   - RAW hazards are resolved by forwarding from EX/MEM, then MEM/WB.
//               Only a load in EX/MEM feeding a used source stalls, for one cycle.
//   undefined - no forwarding. Any EX/MEM or MEM/WB match on a used source
//               stalls the stage. The MEM/WB refresh during hold keeps the
//               stored operands correct for the cycle the stall releases.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid / in_ready             decode handshake
//   id_*                            decoded fields (op, regs, data, imm, shamt, selects, wen, load)
//   flush                           kill the held instruction and any incoming one
//   exm_wen/exm_load/exm_rd/exm_data  EX/MEM writeback info
//   wb_wen/wb_rd/wb_data            MEM/WB writeback info
//   ex_ready / ex_valid             EX handshake
//   alu_a, alu_b, alu_op            ALU operands and op (op forced to 0 when not issuing)
//   ex_rd, ex_wen, ex_load          destination info passed to EX/MEM (wen/load gated)
module id_ex_stage #(
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       id_op,
  input  logic [RF_AW-1:0] id_rs,
  input  logic [RF_AW-1:0] id_rt,
  input  logic [RF_AW-1:0] id_rd,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic [31:0]      id_imm,
  input  logic [4:0]       id_shamt,
  input  logic             id_a_shamt,
  input  logic             id_b_imm,
  input  logic             id_wen,
  input  logic             id_load,
  input  logic             flush,
  input  logic             exm_wen,
  input  logic             exm_load,
  input  logic [RF_AW-1:0] exm_rd,
  input  logic [31:0]      exm_data,
  input  logic             wb_wen,
  input  logic [RF_AW-1:0] wb_rd,
  input  logic [31:0]      wb_data,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  output logic [RF_AW-1:0] ex_rd,
  output logic             ex_wen,
  output logic             ex_load
);

  logic             valid_r;
  logic [3:0]       op_r;
  logic [RF_AW-1:0] rs_r, rt_r, rd_r;
  logic [31:0]      rs_val_r, rt_val_r, imm_r;
  logic [4:0]       shamt_r;
  logic             a_shamt_r, b_imm_r, wen_r, load_r;

  logic use_rs_s, use_rt_s, shift_by_rs_s;
  logic exm_rs_s, exm_rt_s, wb_rs_s, wb_rt_s;
  logic hazard_s, advance_s;
  logic [31:0] a_s, b_s;

  // A stage forwards to a source only if it writes a non-zero register equal to it.
  function automatic logic src_match(input logic wen, input logic [RF_AW-1:0] rd,
                                     input logic [RF_AW-1:0] src);
    return wen && (rd != {RF_AW{1'b0}}) && (rd == src);
  endfunction

  assign exm_rs_s = src_match(exm_wen, exm_rd, rs_r);
  assign exm_rt_s = src_match(exm_wen, exm_rd, rt_r);
  assign wb_rs_s  = src_match(wb_wen, wb_rd, rs_r);
  assign wb_rt_s  = src_match(wb_wen, wb_rd, rt_r);

  // Variable shifts (10..12) read rt even when B carries the immediate.
  always_comb begin
    shift_by_rs_s = 1'b0;
    case (op_r)
      4'd10, 4'd11, 4'd12: shift_by_rs_s = 1'b1;
      default:             shift_by_rs_s = 1'b0;
    endcase
  end

  assign use_rs_s = !a_shamt_r;
  assign use_rt_s = !b_imm_r || shift_by_rs_s;

`ifdef ID_EX_FWD_EN
  // Only a load still in EX/MEM cannot be forwarded yet.
  assign hazard_s = valid_r && exm_load &&
                    ((exm_rs_s && use_rs_s) || (exm_rt_s && use_rt_s));
`else
  logic unused_exm_s;
  assign unused_exm_s = exm_load ^ (|exm_data);
  // Without forwarding, any pending write to a used source stalls.
  assign hazard_s = valid_r &&
                    (((exm_rs_s || wb_rs_s) && use_rs_s) ||
                     ((exm_rt_s || wb_rt_s) && use_rt_s));
`endif

  assign advance_s = !valid_r || (ex_ready && !hazard_s);

  // Operand select with EX/MEM-over-MEM/WB forwarding priority.
  always_comb begin
    a_s = 32'd0;
    b_s = 32'd0;
`ifdef ID_EX_FWD_EN
    if (a_shamt_r)     a_s = {27'd0, shamt_r};
    else if (exm_rs_s) a_s = exm_data;
    else if (wb_rs_s)  a_s = wb_data;
    else               a_s = rs_val_r;
    if (b_imm_r)       b_s = imm_r;
    else if (exm_rt_s) b_s = exm_data;
    else if (wb_rt_s)  b_s = wb_data;
    else               b_s = rt_val_r;
`else
    if (a_shamt_r) a_s = {27'd0, shamt_r};
    else           a_s = rs_val_r;
    if (b_imm_r)   b_s = imm_r;
    else           b_s = rt_val_r;
`endif
  end

  // Stage register: flush beats advance, which beats hold with MEM/WB refresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r   <= 1'b0;
      op_r      <= 4'd0;
      rs_r      <= {RF_AW{1'b0}};
      rt_r      <= {RF_AW{1'b0}};
      rd_r      <= {RF_AW{1'b0}};
      rs_val_r  <= 32'd0;
      rt_val_r  <= 32'd0;
      imm_r     <= 32'd0;
      shamt_r   <= 5'd0;
      a_shamt_r <= 1'b0;
      b_imm_r   <= 1'b0;
      wen_r     <= 1'b0;
      load_r    <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (advance_s) begin
      valid_r   <= in_valid;
      op_r      <= id_op;
      rs_r      <= id_rs;
      rt_r      <= id_rt;
      rd_r      <= id_rd;
      rs_val_r  <= id_rs_data;
      rt_val_r  <= id_rt_data;
      imm_r     <= id_imm;
      shamt_r   <= id_shamt;
      a_shamt_r <= id_a_shamt;
      b_imm_r   <= id_b_imm;
      wen_r     <= id_wen;
      load_r    <= id_load;
    end else begin
      // The retiring MEM/WB write would be lost after this cycle.
      if (wb_rs_s) rs_val_r <= wb_data;
      if (wb_rt_s) rt_val_r <= wb_data;
    end
  end

  assign ex_valid = valid_r && !hazard_s && !flush;
  assign in_ready = advance_s;
  assign alu_a    = a_s;
  assign alu_b    = b_s;
  assign alu_op   = ex_valid ? op_r : 4'd0;
  assign ex_rd    = rd_r;
  assign ex_wen   = wen_r && ex_valid;
  assign ex_load  = load_r && ex_valid;

endmodule
